// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the top FSM and the word assembler.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Largest legal word count for a given address width, as a 17-bit value.
  function automatic logic [16:0] capacity(input int aw);
    return 17'(1) << aw;
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs an accepted byte stream into little-endian 32-bit words.
// word_valid is combinational on the accepting cycle of the 4th byte.
module imem_boot_loader_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  assign o_word       = {i_byte, r_shift};
  assign o_word_valid = i_valid &&
                        (r_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked image, writes it
// into instruction memory from address 0, then releases the CPU reset.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] CAP = capacity(ADDR_WIDTH);

  state_e                r_state;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH:0]   r_idx;
  logic [7:0]            r_xor;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_acc;
  logic [15:0]           w_len;
  logic [ADDR_WIDTH:0]   w_idx_nxt;
  logic                  w_last_word;
  logic [31:0]           w_word;
  logic                  w_word_valid;

  assign rx_ready = (r_state == S_LEN_LO) ||
                    (r_state == S_LEN_HI) ||
                    (r_state == S_DATA)   ||
                    (r_state == S_CSUM);

  assign w_acc       = rx_valid && rx_ready;
  assign w_len       = {rx_data, r_len[7:0]};
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_last_word = (17'(w_idx_nxt) == {1'b0, r_len});

  imem_boot_loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (r_state != S_DATA),
    .i_valid      (w_acc && (r_state == S_DATA)),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_LEN_LO;
      r_len       <= '0;
      r_idx       <= '0;
      r_xor       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_acc) r_xor <= r_xor ^ rx_data;
      unique case (r_state)
        S_LEN_LO: begin
          if (w_acc) begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_acc) begin
            r_len[15:8] <= rx_data;
            if ({1'b0, w_len} > CAP) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            r_we    <= 1'b1;
            r_addr  <= r_idx[ADDR_WIDTH-1:0];
            r_wdata <= w_word;
            r_idx   <= w_idx_nxt;
            if (w_last_word) r_state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (w_acc) begin
            if (r_xor == rx_data) begin
              r_state     <= S_RUN;
              r_cpu_reset <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized image loads against a byte-level reference model.
// Captured writes and final status are compared with the model's prediction.
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  img[$];
  logic [31:0] exp_words[$];
  logic        exp_err;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      got_addr.push_back(32'(imem_addr));
      got_data.push_back(imem_wdata);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: parse the image by its format rules.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_words.delete();
    n = int'(img[0]) + 256 * int'(img[1]);
    if (n > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++)
      exp_words.push_back({img[2+4*k+3], img[2+4*k+2],
                           img[2+4*k+1], img[2+4*k]});
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ img[i];
    exp_err = (x != img[2+4*n]);
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] x;
    logic [31:0] w;
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) img.push_back(w[8*b +: 8]);
    end
    x = 8'h00;
    foreach (img[i]) x = x ^ img[i];
    img.push_back(bad ? x ^ 8'h5A : x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic send(input bit gaps);
    foreach (img[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          rx_valid = 1'b0;
          rx_data  = 8'($urandom);
        end
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = img[i];
      @(posedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic check_result(input string tag);
    int n;
    chk({tag, ".nwrites"}, 32'(got_addr.size()), 32'(exp_words.size()));
    n = got_addr.size() < exp_words.size() ? got_addr.size()
                                           : exp_words.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".addr"}, got_addr[i], 32'(i));
      chk({tag, ".data"}, got_data[i], exp_words[i]);
    end
    chk({tag, ".done"},      32'(done),      32'(!exp_err));
    chk({tag, ".error"},     32'(error),     32'(exp_err));
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
    chk({tag, ".rx_ready"},  32'(rx_ready),  32'(0));
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();

    chk("rst.rx_ready",  32'(rx_ready),  32'(1));
    chk("rst.imem_we",   32'(imem_we),   32'(0));
    chk("rst.imem_addr", 32'(imem_addr), 32'(0));
    chk("rst.wdata",     imem_wdata,     32'(0));
    chk("rst.cpu_reset", 32'(cpu_reset), 32'(1));
    chk("rst.done",      32'(done),      32'(0));
    chk("rst.error",     32'(error),     32'(0));

    // Minimal image
    img = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2C};
    model();
    chk("min.model", exp_words[0], 32'h20080005);
    send(1'b0);
    check_result("min");

    // Bad checksum
    do_reset();
    img = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2D};
    model();
    send(1'b0);
    check_result("badcs");

    // Oversize length; trailing bytes must be ignored
    do_reset();
    img = '{8'h01, 8'h01};
    model();
    send(1'b0);
    chk("over.error_now", 32'(error), 32'(1));
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(1'b1);
    check_result("over");

    // Empty image
    do_reset();
    img = '{8'h00, 8'h00, 8'h00};
    model();
    send(1'b0);
    check_result("empty");

    // Full capacity with random gaps
    do_reset();
    build(1 << AW, 1'b0);
    model();
    send(1'b1);
    check_result("full");

    // Back-to-back throughput
    do_reset();
    build(2, 1'b0);
    model();
    send(1'b0);
    check_result("b2b");
    if (got_cyc.size() == 2)
      chk("b2b.spacing", 32'(got_cyc[1] - got_cyc[0]), 32'(4));
    else
      chk("b2b.pulses", 32'(got_cyc.size()), 32'(2));

    // Reset mid-load, then a clean minimal load
    do_reset();
    img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send(1'b0);
    do_reset();
    img = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2C};
    model();
    send(1'b0);
    check_result("midrst");

    // Random small images, good and bad checksums
    for (int t = 0; t < 6; t++) begin
      do_reset();
      build($urandom_range(1, 9), 1'($urandom_range(0, 1)));
      model();
      send(1'b1);
      check_result($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream boot stage for the single-cycle MIPS core. It holds the CPU in reset while it receives a program image as a byte stream over a valid/ready link. It assembles little-endian 32-bit words and writes them into instruction memory from word address 0. After the image's checksum verifies, it releases the CPU reset. Instruction memory therefore carries a synchronous write port driven only by this block.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  reset for the MIPS core; 1 while loading or in error.
- done  out  1  image loaded and verified; CPU running.
- error  out  1  load failed; CPU held in reset.

## Operation
- Image format, in byte order:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - 4*N payload bytes: each word little-endian, bits [7:0] first.
  - One checksum byte: the XOR of every preceding byte, length bytes included.
- A byte transfers on a rising edge with rx_valid && rx_ready.
- States:
  - S_LEN_LO: accept a byte, go to S_LEN_HI.
  - S_LEN_HI: accept a byte. If N > 2**ADDR_WIDTH, go to S_ERR. If N == 0, go to S_CSUM. Otherwise go to S_DATA.
  - S_DATA: accept bytes. On the 4th byte of word k, issue the write for address k. After word N-1's 4th byte, go to S_CSUM.
  - S_CSUM: accept one byte. If the running XOR equals that byte, go to S_RUN; otherwise go to S_ERR.
  - S_RUN and S_ERR: terminal. Only reset leaves them.
- rx_ready = 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CSUM; 0 in S_RUN and S_ERR.
- Outputs per state:
  - cpu_reset = 1 in every state except S_RUN.
  - done = 1 only in S_RUN.
  - error = 1 only in S_ERR.
- Running XOR covers all accepted bytes before the checksum byte, and is cleared by reset.
- Word index is ADDR_WIDTH+1 bits wide, so N = 2**ADDR_WIDTH is legal. imem_addr takes the low ADDR_WIDTH bits.
- Reset mid-load discards all progress and returns to S_LEN_LO. Memory contents are not cleared; the next image overwrites them.

## Timing
- Reset values: state S_LEN_LO, rx_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, error 0.
- All outputs are registered except rx_ready, which decodes the current state.
- Write latency: imem_we pulses high for exactly one cycle, on the cycle after the 4th byte is accepted. imem_addr and imem_wdata are valid in that cycle and hold until the next write.
- The loader accepts bytes back to back, so a new byte may be accepted in the same cycle as the write pulse. Peak rate is one byte per cycle; stalls (rx_valid = 0) pause all counters.
- State changes follow the accepting edge:
  - cpu_reset falls and done rises one cycle after a matching checksum byte is accepted.
  - error rises one cycle after the offending byte is accepted.
- rx_data is ignored whenever rx_valid = 0 or rx_ready = 0.

## Structure
- A shared include, loader_defs.vh, holds:
  - state encodings S_LEN_LO … S_ERR (3 bits);
  - LEN_BYTES = 2;
  - BYTES_PER_WORD = 4.
- One sub-module, word_assembler, is natural. It takes the accepted byte plus a clear input, keeps a 2-bit byte counter and a 32-bit shift register, and outputs word and word_valid (one-cycle). The top FSM owns the length, the word index, the XOR and the write registers.

## Test plan
- Minimal image: bytes 01 00 05 00 08 20 2C, one per cycle.
  - One write: imem_addr 0, imem_wdata 0x20080005.
  - One cycle after 2C: cpu_reset 0, done 1, rx_ready 0.
- Bad checksum: same image with final byte 2D -> write still occurs; error 1, cpu_reset stays 1, done 0, rx_ready 0.
- Oversize length with ADDR_WIDTH = 8: LEN bytes 01 01 (N = 257) -> error 1 after the second byte; no imem_we.
- Empty image: bytes 00 00 00 -> no writes, done 1. Full image of N = 256 with random rx_valid gaps -> 256 writes at addresses 0..255 in order, then done 1.
- Back-to-back throughput: N = 2, rx_valid held 1 -> imem_we pulses exactly 4 cycles apart, at addresses 0 and 1.
- Reset mid-load: assert reset after 3 payload bytes, then send the minimal image -> first write is addr 0, data 0x20080005; done 1.
